game_phase_sequencer: RTL and testbench

//   Top-level round controller for the SymCounter game. Sequences each round:

---
 rtl/game_pkg.sv | 16 +
 rtl/sync_edge_pulse.sv | 35 +++
 rtl/game_phase_sequencer.sv | 143 ++++++++++++++
 tb/tb_game_phase_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared phase codes and level limits for the SymCounter round controller
package game_pkg;
    localparam int LEVEL_W   = 4;
    localparam int MIN_LEVEL = 1;

    typedef enum logic [2:0] {
        PH_IDLE        = 3'd0,
        PH_PRELIM_REQ  = 3'd1,
        PH_PRELIM_WAIT = 3'd2,
        PH_GAME        = 3'd3,
        PH_RESULT_WIN  = 3'd4,
        PH_RESULT_LOSE = 3'd5,
        PH_CHAMPION    = 3'd6,
        PH_ILLEGAL     = 3'd7
    } phase_e;
endpackage

// File: rtl/sync_edge_pulse.sv
// rtl/sync_edge_pulse.sv - 2-FF synchroniser plus registered rising-edge pulse
module sync_edge_pulse (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);
    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;
    logic pulse_q, pulse_d;

    always_comb begin
        s1_d    = din;
        s2_d    = s1_q;
        s3_d    = s2_q;
        pulse_d = s2_q & ~s3_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;
endmodule

// File: rtl/game_phase_sequencer.sv
// rtl/game_phase_sequencer.sv - round FSM: prelim request, countdown wait, game, result hold
module game_phase_sequencer
    import game_pkg::*;
#(
    parameter int MAX_LEVEL        = 9,
    parameter int RESULT_HOLD_S    = 3,
    parameter int PRELIM_TIMEOUT_S = 15
) (
    input  logic               Clk100M,
    input  logic               Rst_n,
    input  logic               Clk1Hz,
    input  logic               startBtn,
    input  logic               abortBtn,
    input  logic               gameSig,
    input  logic               roundDone,
    input  logic               roundWin,
    output logic               prelimSig,
    output logic               gameStart,
    output logic [LEVEL_W-1:0] curLevel,
    output logic [2:0]         phase,
    output logic               timeoutErr
);
    localparam int CNT_MAX = (RESULT_HOLD_S > PRELIM_TIMEOUT_S) ? RESULT_HOLD_S : PRELIM_TIMEOUT_S;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic sec_tick, start_edge, abort_edge, game_edge;

    sync_edge_pulse u_sec   (.clk(Clk100M), .rst_n(Rst_n), .din(Clk1Hz),   .pulse(sec_tick));
    sync_edge_pulse u_start (.clk(Clk100M), .rst_n(Rst_n), .din(startBtn), .pulse(start_edge));
    sync_edge_pulse u_abort (.clk(Clk100M), .rst_n(Rst_n), .din(abortBtn), .pulse(abort_edge));
    sync_edge_pulse u_game  (.clk(Clk100M), .rst_n(Rst_n), .din(gameSig),  .pulse(game_edge));

    phase_e             state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic               terr_q, terr_d;
    logic               prelim_q, prelim_d;
    logic               gstart_q, gstart_d;

    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        cnt_d    = cnt_q;
        terr_d   = terr_q;
        prelim_d = 1'b0;
        gstart_d = 1'b0;
        cnt_inc  = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + CNT_W'(1);

        // Pulses are registered so they line up with the first cycle of the new state.
        if (abort_edge && (state_q != PH_IDLE)) begin
            state_d = PH_IDLE;
        end else begin
            case (state_q)
                PH_IDLE: begin
                    if (start_edge) begin
                        state_d  = PH_PRELIM_REQ;
                        terr_d   = 1'b0;
                        prelim_d = 1'b1;
                    end
                end
                PH_PRELIM_REQ: begin
                    cnt_d   = '0;
                    state_d = PH_PRELIM_WAIT;
                end
                PH_PRELIM_WAIT: begin
                    if (game_edge) begin
                        state_d  = PH_GAME;
                        gstart_d = 1'b1;
                    end else if (sec_tick) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= CNT_W'(PRELIM_TIMEOUT_S)) begin
                            state_d = PH_IDLE;
                            terr_d  = 1'b1;
                        end
                    end
                end
                PH_GAME: begin
                    if (roundDone) begin
                        cnt_d   = '0;
                        state_d = roundWin ? PH_RESULT_WIN : PH_RESULT_LOSE;
                    end
                end
                PH_RESULT_WIN: begin
                    if (sec_tick) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= CNT_W'(RESULT_HOLD_S)) begin
                            if (level_q >= LEVEL_W'(MAX_LEVEL)) begin
                                state_d = PH_CHAMPION;
                                level_d = LEVEL_W'(MAX_LEVEL);
                            end else begin
                                state_d  = PH_PRELIM_REQ;
                                level_d  = level_q + LEVEL_W'(1);
                                prelim_d = 1'b1;
                            end
                        end
                    end
                end
                PH_RESULT_LOSE: begin
                    if (sec_tick) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= CNT_W'(RESULT_HOLD_S)) begin
                            state_d = PH_IDLE;
                            level_d = LEVEL_W'(MIN_LEVEL);
                        end
                    end
                end
                PH_CHAMPION: begin
                    level_d = LEVEL_W'(MAX_LEVEL);
                    if (start_edge) begin
                        state_d  = PH_PRELIM_REQ;
                        level_d  = LEVEL_W'(MIN_LEVEL);
                        prelim_d = 1'b1;
                    end
                end
                default: state_d = PH_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= PH_IDLE;
            level_q  <= LEVEL_W'(MIN_LEVEL);
            cnt_q    <= '0;
            terr_q   <= 1'b0;
            prelim_q <= 1'b0;
            gstart_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            terr_q   <= terr_d;
            prelim_q <= prelim_d;
            gstart_q <= gstart_d;
        end
    end

    assign prelimSig  = prelim_q;
    assign gameStart  = gstart_q;
    assign curLevel   = level_q;
    assign phase      = state_q;
    assign timeoutErr = terr_q;
endmodule

// File: tb/tb_game_phase_sequencer.sv
// tb/tb_game_phase_sequencer.sv - directed self-checking bench for game_phase_sequencer
module tb_game_phase_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk1hz = 1'b0;
    logic       start_btn = 1'b0;
    logic       abort_btn = 1'b0;
    logic       game_sig = 1'b0;
    logic       round_done = 1'b0;
    logic       round_win = 1'b0;
    logic       prelim_sig;
    logic       game_start;
    logic [3:0] cur_level;
    logic [2:0] phase;
    logic       timeout_err;

    int tests = 0;
    int fails = 0;

    game_phase_sequencer dut (
        .Clk100M   (clk),
        .Rst_n     (rst_n),
        .Clk1Hz    (clk1hz),
        .startBtn  (start_btn),
        .abortBtn  (abort_btn),
        .gameSig   (game_sig),
        .roundDone (round_done),
        .roundWin  (round_win),
        .prelimSig (prelim_sig),
        .gameStart (game_start),
        .curLevel  (cur_level),
        .phase     (phase),
        .timeoutErr(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_prelim(input string tag);
        logic found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            found = prelim_sig;
        end
        chk(tag, 8'(found), 8'd1);
    endtask

    task automatic wait_gstart(input string tag);
        logic found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            found = game_start;
        end
        chk(tag, 8'(found), 8'd1);
    endtask

    task automatic tick();
        clk1hz = 1'b1;
        cyc(4);
        clk1hz = 1'b0;
        cyc(4);
    endtask

    task automatic press_start(input string tag);
        start_btn = 1'b1;
        wait_prelim(tag);
        start_btn = 1'b0;
    endtask

    task automatic enter_game(input string tag);
        game_sig = 1'b1;
        wait_gstart(tag);
        game_sig = 1'b0;
        cyc(1);
    endtask

    task automatic finish_round(input logic win);
        round_done = 1'b1;
        round_win  = win;
        cyc(1);
        round_done = 1'b0;
        round_win  = 1'b0;
    endtask

    // Full winning round from PRELIM_WAIT; the last hold tick is held high so the
    // following prelimSig pulse can be caught while it is live.
    task automatic win_round(input string tag, input logic expect_prelim);
        enter_game({tag, "_gstart"});
        finish_round(1'b1);
        tick();
        tick();
        if (expect_prelim) begin
            clk1hz = 1'b1;
            wait_prelim({tag, "_prelim"});
            clk1hz = 1'b0;
            cyc(4);
        end else begin
            tick();
        end
    endtask

    initial begin
        cyc(3);
        chk("rst_phase", 8'(phase), 8'd0);
        chk("rst_level", 8'(cur_level), 8'd1);
        chk("rst_prelim", 8'(prelim_sig), 8'd0);
        chk("rst_gstart", 8'(game_start), 8'd0);
        chk("rst_terr", 8'(timeout_err), 8'd0);
        rst_n = 1'b1;
        cyc(3);
        chk("idle_phase", 8'(phase), 8'd0);

        // First round: start, countdown done, win, auto-advance to level 2
        press_start("start1_prelim");
        chk("start1_phase_req", 8'(phase), 8'd1);
        chk("start1_level", 8'(cur_level), 8'd1);
        cyc(1);
        chk("start1_prelim_1cyc", 8'(prelim_sig), 8'd0);
        chk("start1_phase_wait", 8'(phase), 8'd2);
        game_sig = 1'b1;
        wait_gstart("game1_gstart");
        chk("game1_phase", 8'(phase), 8'd3);
        chk("game1_no_prelim", 8'(prelim_sig), 8'd0);
        game_sig = 1'b0;
        cyc(1);
        chk("game1_gstart_1cyc", 8'(game_start), 8'd0);
        finish_round(1'b1);
        chk("win1_phase", 8'(phase), 8'd4);
        tick();
        tick();
        chk("win1_hold2_phase", 8'(phase), 8'd4);
        clk1hz = 1'b1;
        wait_prelim("win1_next_prelim");
        clk1hz = 1'b0;
        chk("win1_level2", 8'(cur_level), 8'd2);
        cyc(4);

        // Climb to level 4, then abort mid-game
        win_round("w2", 1'b1);
        win_round("w3", 1'b1);
        chk("lvl4_level", 8'(cur_level), 8'd4);
        enter_game("abort_gstart");
        abort_btn = 1'b1;
        cyc(6);
        abort_btn = 1'b0;
        chk("abort_phase", 8'(phase), 8'd0);
        chk("abort_level_kept", 8'(cur_level), 8'd4);
        chk("abort_no_prelim", 8'(prelim_sig), 8'd0);
        abort_btn = 1'b1;
        cyc(6);
        abort_btn = 1'b0;
        chk("abort_idle_noop", 8'(phase), 8'd0);

        // Restart at level 4, win to 5, then lose
        press_start("restart_prelim");
        chk("restart_level", 8'(cur_level), 8'd4);
        cyc(4);
        win_round("w4", 1'b1);
        chk("lvl5_level", 8'(cur_level), 8'd5);
        enter_game("lose_gstart");
        finish_round(1'b0);
        chk("lose_phase", 8'(phase), 8'd5);
        tick();
        tick();
        chk("lose_hold2_phase", 8'(phase), 8'd5);
        tick();
        chk("lose_done_phase", 8'(phase), 8'd0);
        chk("lose_level_reset", 8'(cur_level), 8'd1);

        // Champion run: eight wins bring level to 9, the ninth win crowns
        press_start("champ_start");
        cyc(4);
        for (int l = 1; l < 9; l++) win_round("cw", 1'b1);
        chk("champ_pre_level", 8'(cur_level), 8'd9);
        win_round("cw9", 1'b0);
        chk("champ_phase", 8'(phase), 8'd6);
        chk("champ_level", 8'(cur_level), 8'd9);
        press_start("champ_restart_prelim");
        chk("champ_restart_level", 8'(cur_level), 8'd1);
        cyc(4);

        // Prelim timeout after 15 ticks without gameSig
        for (int t = 0; t < 14; t++) tick();
        chk("to_14_phase", 8'(phase), 8'd2);
        chk("to_14_terr", 8'(timeout_err), 8'd0);
        tick();
        chk("to_15_phase", 8'(phase), 8'd0);
        chk("to_15_terr", 8'(timeout_err), 8'd1);
        press_start("to_restart_prelim");
        chk("to_restart_terr_clr", 8'(timeout_err), 8'd0);
        cyc(4);

        // gameSig edge coinciding with the 15th tick wins
        for (int t = 0; t < 14; t++) tick();
        game_sig = 1'b1;
        clk1hz   = 1'b1;
        wait_gstart("race_gstart");
        chk("race_phase", 8'(phase), 8'd3);
        chk("race_terr", 8'(timeout_err), 8'd0);

        // Asynchronous reset mid-game, while gameStart is high
        rst_n = 1'b0;
        #1;
        chk("arst_gstart", 8'(game_start), 8'd0);
        chk("arst_phase", 8'(phase), 8'd0);
        chk("arst_level", 8'(cur_level), 8'd1);
        chk("arst_prelim", 8'(prelim_sig), 8'd0);
        chk("arst_terr", 8'(timeout_err), 8'd0);
        game_sig = 1'b0;
        clk1hz   = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(8);
        chk("arst_release_phase", 8'(phase), 8'd0);
        chk("arst_release_prelim", 8'(prelim_sig), 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
